// File: rtl/mem_block_mover_if.sv
// Command/status and data-memory port bundle between the mover and its surroundings.
// master = the mover (bus initiator); slave = controller plus data memory.
interface mem_block_mover_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter int LEN_W  = 6
);
   logic              start;
   logic              mode;
   logic [ADDR_W-1:0] src_addr;
   logic [ADDR_W-1:0] dst_addr;
   logic [LEN_W-1:0]  length;
   logic [DATA_W-1:0] fill_value;
   logic [DATA_W-1:0] ReadData;
   logic [ADDR_W-1:0] Address;
   logic [DATA_W-1:0] WriteData;
   logic              MemRead;
   logic              MemWrite;
   logic              busy;
   logic              done;
   logic              error;

   modport master (
      input  start, mode, src_addr, dst_addr, length, fill_value, ReadData,
      output Address, WriteData, MemRead, MemWrite, busy, done, error
   );

   modport slave (
      output start, mode, src_addr, dst_addr, length, fill_value, ReadData,
      input  Address, WriteData, MemRead, MemWrite, busy, done, error
   );
endinterface

// File: rtl/mem_block_mover.sv
// Block copy (memmove semantics) or constant fill on the data-memory port.
// Copies alternate READ/WRITE per byte; fills issue one WRITE per byte.
module mem_block_mover #(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 8,
   parameter int MEM_DEPTH = 32,
   parameter int LEN_W     = 6
) (
   input  logic              clk,
   input  logic              reset,
   mem_block_mover_if.master bus
);

   localparam int SUM_W = ADDR_W + 1;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      READ,
      WRITE,
      FINISH
   } state_t;

   state_t            state_q, state_d;
   logic              mode_q,  mode_d;
   logic              back_q,  back_d;
   logic              error_q, error_d;
   logic [ADDR_W-1:0] src_q,   src_d;
   logic [ADDR_W-1:0] dst_q,   dst_d;
   logic [LEN_W-1:0]  len_q,   len_d;
   logic [LEN_W-1:0]  idx_q,   idx_d;
   logic [DATA_W-1:0] fill_q,  fill_d;
   logic [DATA_W-1:0] hold_q,  hold_d;

   // Range sums carry one extra bit so base+length can never wrap.
   logic [SUM_W-1:0] len_ext;
   logic [SUM_W-1:0] src_end;
   logic [SUM_W-1:0] dst_end;
   logic             range_err;
   logic             go_backward;
   logic             last_byte;

   assign len_ext     = SUM_W'(len_q);
   assign src_end     = {1'b0, src_q} + len_ext;
   assign dst_end     = {1'b0, dst_q} + len_ext;
   assign range_err   = (dst_end > SUM_W'(MEM_DEPTH)) ||
                        (!mode_q && (src_end > SUM_W'(MEM_DEPTH)));
   assign go_backward = !mode_q && (src_q < dst_q) && ({1'b0, dst_q} < src_end);
   assign last_byte   = back_q ? (idx_q == '0) : (idx_q == len_q - LEN_W'(1));

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of every other flop, regardless of statement order.
   // NOTE: the command and hold registers are reset alongside the FSM; they are
   // a handful of flops, not a memory array, so the reset costs nothing real.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         mode_q  <= 1'b0;
         back_q  <= 1'b0;
         error_q <= 1'b0;
         src_q   <= '0;
         dst_q   <= '0;
         len_q   <= '0;
         idx_q   <= '0;
         fill_q  <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         back_q  <= back_d;
         error_q <= error_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         fill_q  <= fill_d;
         hold_q  <= hold_d;
      end
   end

   // NOTE: every variable gets its hold value first, so no path through the
   // case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      back_d  = back_q;
      error_d = error_q;
      src_d   = src_q;
      dst_d   = dst_q;
      len_d   = len_q;
      idx_d   = idx_q;
      fill_d  = fill_q;
      hold_d  = hold_q;

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               mode_d  = bus.mode;
               src_d   = bus.src_addr;
               dst_d   = bus.dst_addr;
               len_d   = bus.length;
               fill_d  = bus.fill_value;
               error_d = 1'b0;
               state_d = CHECK;
            end
         end
         CHECK: begin
            if (len_q == '0) begin
               state_d = FINISH;
            end else if (range_err) begin
               error_d = 1'b1;
               state_d = FINISH;
            end else begin
               back_d  = go_backward;
               idx_d   = go_backward ? len_q - LEN_W'(1) : '0;
               state_d = mode_q ? WRITE : READ;
            end
         end
         READ: begin
            hold_d  = bus.ReadData;
            state_d = WRITE;
         end
         WRITE: begin
            idx_d = back_q ? idx_q - LEN_W'(1) : idx_q + LEN_W'(1);
            if (last_byte) begin
               state_d = FINISH;
            end else begin
               state_d = mode_q ? WRITE : READ;
            end
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Moore outputs: strobes and address come from state and registers only.
   always_comb begin
      bus.Address   = '0;
      bus.WriteData = '0;
      bus.MemRead   = 1'b0;
      bus.MemWrite  = 1'b0;
      unique case (state_q)
         READ: begin
            bus.Address = src_q + ADDR_W'(idx_q);
            bus.MemRead = 1'b1;
         end
         WRITE: begin
            bus.Address   = dst_q + ADDR_W'(idx_q);
            bus.MemWrite  = 1'b1;
            bus.WriteData = mode_q ? fill_q : hold_q;
         end
         default: begin
         end
      endcase
   end

   assign bus.busy  = (state_q == CHECK) || (state_q == READ) || (state_q == WRITE);
   assign bus.done  = (state_q == FINISH);
   assign bus.error = error_q;

endmodule

// File: tb/tb_mem_block_mover.sv
// Directed bench for mem_block_mover with a combinational-read data memory model.
module tb_mem_block_mover;

   localparam int ADDR_W    = 8;
   localparam int DATA_W    = 8;
   localparam int MEM_DEPTH = 32;
   localparam int LEN_W     = 6;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   mem_block_mover_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus_if ();

   mem_block_mover #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH), .LEN_W(LEN_W)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus_if)
   );

   logic [DATA_W-1:0] mem [0:MEM_DEPTH-1];

   assign bus_if.ReadData = (int'(bus_if.Address) < MEM_DEPTH) ? mem[bus_if.Address[4:0]] : '0;

   always @(posedge clk) begin
      if (bus_if.MemWrite && (int'(bus_if.Address) < MEM_DEPTH))
         mem[bus_if.Address[4:0]] <= bus_if.WriteData;
   end

   int n_checks = 0;
   int n_errors = 0;

   int   n_busy, n_rd, n_wr, n_both, done_at;
   logic err_at_done, err_at_chk, aborted;
   logic [ADDR_W-1:0] rd_q[$];
   logic [ADDR_W-1:0] wr_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_addr"},  32'(bus_if.Address),   0);
      check({tag, "_wdata"}, 32'(bus_if.WriteData), 0);
      check({tag, "_rd"},    32'(bus_if.MemRead),   0);
      check({tag, "_wr"},    32'(bus_if.MemWrite),  0);
      check({tag, "_busy"},  32'(bus_if.busy),      0);
      check({tag, "_done"},  32'(bus_if.done),      0);
      check({tag, "_err"},   32'(bus_if.error),     0);
   endtask

   task automatic check_mem(input string tag, input int a, input logic [7:0] exp);
      check($sformatf("%s_mem%0d", tag, a), 32'(mem[a]), 32'(exp));
   endtask

   // Issues one command and records per-cycle activity, sampled on negedges.
   // poke_k>0 re-pulses start with other arguments at that cycle and in FINISH;
   // abort_k>0 pulls reset low in that cycle.
   task automatic run_op(input logic m, input logic [7:0] s, input logic [7:0] d,
                         input logic [5:0] l, input logic [7:0] f,
                         input int poke_k, input int abort_k);
      int k;
      n_busy = 0; n_rd = 0; n_wr = 0; n_both = 0; done_at = 0;
      err_at_done = 1'b0; err_at_chk = 1'b1; aborted = 1'b0;
      rd_q.delete();
      wr_q.delete();
      @(negedge clk);
      bus_if.mode       = m;
      bus_if.src_addr   = s;
      bus_if.dst_addr   = d;
      bus_if.length     = l;
      bus_if.fill_value = f;
      bus_if.start      = 1'b1;
      @(negedge clk);
      bus_if.start = 1'b0;
      k = 1;
      while (done_at == 0 && !aborted && k <= 200) begin
         if (bus_if.busy) n_busy++;
         if (bus_if.MemRead) begin n_rd++; rd_q.push_back(bus_if.Address); end
         if (bus_if.MemWrite) begin n_wr++; wr_q.push_back(bus_if.Address); end
         if (bus_if.MemRead && bus_if.MemWrite) n_both++;
         if (k == 1) err_at_chk = bus_if.error;
         if (bus_if.done) begin done_at = k; err_at_done = bus_if.error; end
         if (k == abort_k) begin
            reset = 1'b0;
            #1;
            check_zero("abort");
            aborted = 1'b1;
         end else begin
            if (poke_k > 0 && (k == poke_k || bus_if.done)) begin
               bus_if.mode       = ~m;
               bus_if.src_addr   = 8'd5;
               bus_if.dst_addr   = 8'd6;
               bus_if.length     = 6'd1;
               bus_if.fill_value = 8'h55;
               bus_if.start      = 1'b1;
            end else begin
               bus_if.start = 1'b0;
            end
            @(negedge clk);
            k++;
         end
      end
      bus_if.start = 1'b0;
      if (!aborted) begin
         check("post_done", 32'(bus_if.done), 0);
         check("post_busy", 32'(bus_if.busy), 0);
         check("no_both",   32'(n_both),      0);
      end
   endtask

   task automatic load_mem();
      for (int i = 0; i < MEM_DEPTH; i++)
         mem[i] <= (i < 16) ? 8'(i) : 8'hEE;
      @(negedge clk);
   endtask

   task automatic check_copy_0_20(input string tag);
      check({tag, "_done_at"}, 32'(done_at), 10);
      check({tag, "_busy"},    32'(n_busy),  9);
      check({tag, "_nrd"},     32'(n_rd),    4);
      check({tag, "_nwr"},     32'(n_wr),    4);
      check({tag, "_err"},     32'(err_at_done), 0);
      if (rd_q.size() == 4 && wr_q.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_rd%0d", tag, i), 32'(rd_q[i]), 32'(i));
            check($sformatf("%s_wr%0d", tag, i), 32'(wr_q[i]), 32'(20 + i));
            check_mem(tag, 20 + i, 8'(i));
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus_if.start      = 1'b0;
      bus_if.mode       = 1'b0;
      bus_if.src_addr   = '0;
      bus_if.dst_addr   = '0;
      bus_if.length     = '0;
      bus_if.fill_value = '0;
      #2;
      check_zero("reset");
      load_mem();
      reset = 1'b1;

      // 1: plain forward copy 0 -> 20
      run_op(1'b0, 8'd0, 8'd20, 6'd4, 8'h00, 0, 0);
      check_copy_0_20("s1");

      // 5: abort during the write of byte 2 (address 22)
      for (int i = 20; i < 24; i++) mem[i] <= 8'hEE;
      @(negedge clk);
      run_op(1'b0, 8'd0, 8'd20, 6'd4, 8'h00, 0, 7);
      check("s5_wr_cnt", 32'(wr_q.size()), 3);
      if (wr_q.size() == 3) check("s5_wr_last", 32'(wr_q[2]), 22);
      repeat (2) @(negedge clk);
      check_zero("s5_held");
      reset = 1'b1;
      @(negedge clk);
      check_mem("s5", 20, 8'h00);
      check_mem("s5", 21, 8'h01);
      check_mem("s5", 22, 8'hEE);
      check_mem("s5", 23, 8'hEE);
      run_op(1'b0, 8'd0, 8'd20, 6'd4, 8'h00, 0, 0);
      check_copy_0_20("s5r");

      // 2: fill 8..10 with AA
      run_op(1'b1, 8'd0, 8'd8, 6'd3, 8'hAA, 0, 0);
      check("s2_done_at", 32'(done_at), 5);
      check("s2_nwr",     32'(n_wr),    3);
      check("s2_nrd",     32'(n_rd),    0);
      check("s2_err",     32'(err_at_done), 0);
      check_mem("s2", 7,  8'h07);
      for (int i = 8; i < 11; i++) check_mem("s2", i, 8'hAA);
      check_mem("s2", 11, 8'h0B);

      // 3: overlapping copy 0 -> 2 runs backward
      run_op(1'b0, 8'd0, 8'd2, 6'd4, 8'h00, 0, 0);
      check("s3_done_at", 32'(done_at), 10);
      check("s3_nwr",     32'(wr_q.size()), 4);
      if (wr_q.size() == 4 && rd_q.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            check($sformatf("s3_wr%0d", i), 32'(wr_q[i]), 32'(5 - i));
            check($sformatf("s3_rd%0d", i), 32'(rd_q[i]), 32'(3 - i));
         end
      end
      check_mem("s3", 0, 8'h00);
      check_mem("s3", 1, 8'h01);
      for (int i = 0; i < 4; i++) check_mem("s3", 2 + i, 8'(i));

      // 4: source range error
      run_op(1'b0, 8'd30, 8'd0, 6'd4, 8'h00, 0, 0);
      check("s4_done_at", 32'(done_at), 2);
      check("s4_err",     32'(err_at_done), 1);
      check("s4_nrd",     32'(n_rd), 0);
      check("s4_nwr",     32'(n_wr), 0);
      check("s4_err_hold", 32'(bus_if.error), 1);

      // 6a: zero length clears error at acceptance
      run_op(1'b0, 8'd0, 8'd4, 6'd0, 8'h00, 0, 0);
      check("s6a_err_chk", 32'(err_at_chk), 0);
      check("s6a_done_at", 32'(done_at), 2);
      check("s6a_err",     32'(err_at_done), 0);
      check("s6a_strobes", 32'(n_rd + n_wr), 0);

      // 6b: start pulses while busy and in FINISH are ignored
      run_op(1'b0, 8'd0, 8'd24, 6'd2, 8'h00, 2, 0);
      check("s6b_done_at", 32'(done_at), 6);
      check("s6b_nwr",     32'(n_wr), 2);
      check_mem("s6b", 24, 8'h00);
      check_mem("s6b", 25, 8'h01);
      check_mem("s6b", 6,  8'h06);

      // Boundaries: ending exactly at MEM_DEPTH is legal, one past is not
      run_op(1'b1, 8'd0, 8'd28, 6'd4, 8'h3C, 0, 0);
      check("bnd_ok_done_at", 32'(done_at), 6);
      check("bnd_ok_err",     32'(err_at_done), 0);
      check_mem("bnd", 31, 8'h3C);
      run_op(1'b1, 8'd0, 8'd29, 6'd4, 8'h77, 0, 0);
      check("bnd_bad_done_at", 32'(done_at), 2);
      check("bnd_bad_err",     32'(err_at_done), 1);
      check("bnd_bad_nwr",     32'(n_wr), 0);

      // src == dst copy rewrites in place, forward
      run_op(1'b0, 8'd8, 8'd8, 6'd2, 8'h00, 0, 0);
      check("same_done_at", 32'(done_at), 6);
      if (wr_q.size() == 2) check("same_wr0", 32'(wr_q[0]), 8);
      check_mem("same", 8, 8'hAA);
      check_mem("same", 9, 8'hAA);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
